six_three_popcount_ctrl: RTL and testbench

//  Sequencer that time-shares ONE six_three_counter instance to popcount an N-bit vector.

---
 rtl/six_three_popcount_ctrl.sv | 137 +++++++++++++
 tb/tb_six_three_popcount_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/six_three_popcount_ctrl.sv
// rtl/six_three_popcount_ctrl.sv - time-shared 6:3 counter popcount sequencer
// Optional self-check of the 6:3 counter enabled by defining SIX_THREE_SELFCHECK_EN.

module six_three_counter (
    input  logic [5:0] x,
    output logic       s,
    output logic       c1,
    output logic       c2
);
    logic sa, ca, sb, cb, t;

    // Two full adders on each half, then combine the weight-1 and weight-2 columns.
    assign sa = x[0] ^ x[1] ^ x[2];
    assign ca = (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
    assign sb = x[3] ^ x[4] ^ x[5];
    assign cb = (x[3] & x[4]) | (x[3] & x[5]) | (x[4] & x[5]);
    assign s  = sa ^ sb;
    assign t  = sa & sb;
    assign c1 = ca ^ cb ^ t;
    assign c2 = (ca & cb) | (ca & t) | (cb & t);
endmodule

module six_three_popcount_ctrl #(
    parameter  int N      = 24,
    localparam int CHUNKS = (N + 5) / 6,
    localparam int CW     = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  vec_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count_o,
    output logic          busy,
    output logic          err_o
);
    localparam int PW = CHUNKS * 6;
    localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int AW = (CW > 3) ? CW : 3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   acc_q, acc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]   count_q, count_d;
    logic            cnt_s, cnt_c1, cnt_c2;
    logic [2:0]      chunk_sum;
    logic [AW-1:0]   acc_sum;

    six_three_counter u_cnt (
        .x  (shreg_q[5:0]),
        .s  (cnt_s),
        .c1 (cnt_c1),
        .c2 (cnt_c2)
    );

    assign chunk_sum = {cnt_c2, cnt_c1, cnt_s};
    // Widen to at least 3 bits so tiny N cannot truncate the chunk sum before the add.
    assign acc_sum   = AW'(acc_q) + AW'(chunk_sum);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d = PW'(vec_i);
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_sum[CW-1:0];
                shreg_d = shreg_q >> 6;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(CHUNKS - 1)) begin
                    count_d = acc_sum[CW-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign count_o   = count_q;

`ifdef SIX_THREE_SELFCHECK_EN
    logic       err_q;
    logic [2:0] ref_cnt;

    assign ref_cnt = 3'($countones(shreg_q[5:0]));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == RUN && ref_cnt != chunk_sum) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_six_three_popcount_ctrl.sv
// tb/tb_six_three_popcount_ctrl.sv - scoreboard bench for six_three_popcount_ctrl
// Exercises N=24, N=20 and N=5 instances; force test only with SIX_THREE_SELFCHECK_EN.

module tb_six_three_popcount_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int exp;
        int acyc;
    } sb_t;

    logic rst_n;

    // N = 24 instance
    logic        in_valid, in_ready, out_valid, out_ready, busy, err;
    logic [23:0] vec;
    logic [4:0]  count;
    six_three_popcount_ctrl #(.N(24)) d24 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .vec_i(vec),
        .out_valid(out_valid), .out_ready(out_ready), .count_o(count), .busy(busy), .err_o(err)
    );

    // N = 20 instance
    logic        iv20, ir20, ov20, busy20, err20;
    logic        or20 = 1'b1;
    logic [19:0] vec20;
    logic [4:0]  cnt20;
    six_three_popcount_ctrl #(.N(20)) d20 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv20), .in_ready(ir20), .vec_i(vec20),
        .out_valid(ov20), .out_ready(or20), .count_o(cnt20), .busy(busy20), .err_o(err20)
    );

    // N = 5 instance
    logic        iv5, ir5, ov5, busy5, err5;
    logic        or5 = 1'b1;
    logic [4:0]  vec5;
    logic [2:0]  cnt5;
    six_three_popcount_ctrl #(.N(5)) d5 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_ready(ir5), .vec_i(vec5),
        .out_valid(ov5), .out_ready(or5), .count_o(cnt5), .busy(busy5), .err_o(err5)
    );

    sb_t q24[$];
    sb_t q20[$];
    sb_t q5[$];

    int rdy_mode   = 0;
    bit ignore_out = 0;
    bit holding    = 0;
    int held       = 0;

    // Monitor for N=24: owns out_ready, checks result, latency and hold stability.
    initial out_ready = 1'b0;
    always @(negedge clk) begin
        sb_t e;
        if (rst_n && out_valid && !ignore_out) begin
            if (!holding) begin
                if (q24.size() == 0) begin
                    chk("spurious_out_valid_24", 32'(out_valid), 32'd0);
                end else begin
                    e = q24.pop_front();
                    chk("count_24", 32'(count), 32'(e.exp));
                    chk("latency_24", 32'(cyc - e.acyc), 32'd4);
                    chk("err_o_24", 32'(err), 32'd0);
                end
                held    = int'(count);
                holding = 1;
            end else begin
                chk("hold_count_24", 32'(count), 32'(held));
                chk("hold_in_ready_24", 32'(in_ready), 32'd0);
            end
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            if (out_ready) holding = 0;
        end else begin
            holding   = 0;
            out_ready = ignore_out ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        sb_t e;
        if (rst_n && ov20) begin
            if (q20.size() == 0) begin
                chk("spurious_out_valid_20", 32'(ov20), 32'd0);
            end else begin
                e = q20.pop_front();
                chk("count_20", 32'(cnt20), 32'(e.exp));
                chk("latency_20", 32'(cyc - e.acyc), 32'd4);
            end
        end
    end

    always @(negedge clk) begin
        sb_t e;
        if (rst_n && ov5) begin
            if (q5.size() == 0) begin
                chk("spurious_out_valid_5", 32'(ov5), 32'd0);
            end else begin
                e = q5.pop_front();
                chk("count_5", 32'(cnt5), 32'(e.exp));
                chk("latency_5", 32'(cyc - e.acyc), 32'd1);
            end
        end
    end

    task automatic send24(input logic [23:0] v, input int exp, input bit push);
        int k = 0;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("in_ready_timeout_24", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        vec      = v;
        if (push) q24.push_back('{exp, cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send20(input logic [19:0] v, input int exp);
        int k = 0;
        @(negedge clk);
        while (!ir20 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!ir20) chk("in_ready_timeout_20", 32'(ir20), 32'd1);
        iv20  = 1'b1;
        vec20 = v;
        q20.push_back('{exp, cyc + 1});
        @(negedge clk);
        iv20 = 1'b0;
    endtask

    task automatic send5(input logic [4:0] v, input int exp);
        int k = 0;
        @(negedge clk);
        while (!ir5 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!ir5) chk("in_ready_timeout_5", 32'(ir5), 32'd1);
        iv5  = 1'b1;
        vec5 = v;
        q5.push_back('{exp, cyc + 1});
        @(negedge clk);
        iv5 = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((q24.size() != 0 || q20.size() != 0 || q5.size() != 0 || busy) && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", 32'(k < 500), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] rv;
        int k;
        rst_n = 1'b0;
        in_valid = 1'b0; vec = '0;
        iv20 = 1'b0; vec20 = '0;
        iv5 = 1'b0; vec5 = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // T1/T2 directed vectors
        send24(24'hFFFFFF, 24, 1);
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_in_ready", 32'(in_ready), 32'd0);
        send24(24'h000000, 0, 1);
        send24(24'h000001, 1, 1);
        send24(24'h800000, 1, 1);
        send24(24'hA5A5A5, 12, 1);
        send24(24'h123456, 9, 1);

        // T3 narrower instances, padding contributes nothing
        send20(20'hFFFFF, 20);
        send20(20'h80001, 2);
        send5(5'h1F, 5);
        send5(5'h0A, 2);
        drain();

        // T4 stall in DONE with ignored input pulses
        rdy_mode = 2;
        send24(24'h0F0F0F, 12, 1);
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t4_out_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            vec      = 24'hFFFFFF;
            @(negedge clk);
            chk("t4_out_valid_held", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        rdy_mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk("t4_in_ready_after", 32'(in_ready), 32'd1);
        chk("t4_out_valid_after", 32'(out_valid), 32'd0);

        // T5 reset during RUN at idx=2
        send24(24'hFFFFFF, 24, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        chk("t5_count", 32'(count), 32'd0);
        send24(24'h000007, 3, 1);
        drain();

        // T6 back-to-back random vectors, random out_ready
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            rv = 24'($urandom);
            send24(rv, $countones(rv), 1);
        end
        rdy_mode = 0;
        drain();
        chk("t6_err_o", 32'(err), 32'd0);

`ifdef SIX_THREE_SELFCHECK_EN
        ignore_out = 1;
        force d24.cnt_c2 = 1'b1;
        send24(24'h000000, 0, 0);
        repeat (6) @(negedge clk);
        chk("force_err_set", 32'(err), 32'd1);
        release d24.cnt_c2;
        send24(24'h000003, 2, 0);
        repeat (6) @(negedge clk);
        chk("force_err_sticky", 32'(err), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ignore_out = 0;
        chk("force_err_cleared", 32'(err), 32'd0);
`endif

        chk("q24_empty", 32'(q24.size()), 32'd0);
        chk("q20_empty", 32'(q20.size()), 32'd0);
        chk("q5_empty", 32'(q5.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
